// File: rtl/alu_operand_server_if.sv
// Issue-side request, ALU operand/result channel, external fill and status between the operand server and its peers.
// The server uses the slave modport; the issue unit / ALU side uses master.
interface alu_operand_server_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_op0_addr_i;
  logic [ADDR_WIDTH-1:0] req_op1_addr_i;
  logic [ADDR_WIDTH-1:0] req_opd_addr_i;
  logic [DATA_WIDTH-1:0] op0_data_o;
  logic [DATA_WIDTH-1:0] op1_data_o;
  logic                  op0_valid_o;
  logic                  op1_valid_o;
  logic [ADDR_WIDTH-1:0] opd_addr_o;
  logic                  opd_store_success_o;
  logic                  opd_valid_i;
  logic [ADDR_WIDTH-1:0] opd_addr_i;
  logic [DATA_WIDTH-1:0] opd_data_i;
  logic                  fill_valid_i;
  logic [ADDR_WIDTH-1:0] fill_addr_i;
  logic [DATA_WIDTH-1:0] fill_data_i;
  logic                  flush_i;
  logic                  instr_done_o;
  logic                  err_o;

  modport slave (
    input  req_valid_i, req_op0_addr_i, req_op1_addr_i, req_opd_addr_i,
    input  opd_valid_i, opd_addr_i, opd_data_i,
    input  fill_valid_i, fill_addr_i, fill_data_i, flush_i,
    output req_ready_o, op0_data_o, op1_data_o, op0_valid_o, op1_valid_o,
    output opd_addr_o, opd_store_success_o, instr_done_o, err_o
  );

  modport master (
    output req_valid_i, req_op0_addr_i, req_op1_addr_i, req_opd_addr_i,
    output opd_valid_i, opd_addr_i, opd_data_i,
    output fill_valid_i, fill_addr_i, fill_data_i, flush_i,
    input  req_ready_o, op0_data_o, op1_data_o, op0_valid_o, op1_valid_o,
    input  opd_addr_o, opd_store_success_o, instr_done_o, err_o
  );
endinterface

// File: rtl/alu_operand_server.sv
// Operand cache + IDLE/EXEC/DONE sequencer feeding the ALU; result lands one cycle after a matching opd_valid_i.
// One instruction in flight: req_ready_o is low for the whole EXEC state, which waits indefinitely for the ALU.
module alu_operand_server #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_operand_server_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] op0_addr_q;
  logic [ADDR_WIDTH-1:0] op1_addr_q;
  logic [ADDR_WIDTH-1:0] opd_addr_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic                  ready_q;
  logic                  succ_q;
  logic                  done_q;
  logic                  err_q;

  logic wb_hit;
  logic wb_miss;

  assign wb_hit  = (state_q == EXEC) && bus.opd_valid_i && (bus.opd_addr_i == opd_addr_q);
  assign wb_miss = (state_q == EXEC) && bus.opd_valid_i && (bus.opd_addr_i != opd_addr_q);

  // Writeback is assigned after the fill so it wins on an address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q <= '0;
    end else if (bus.flush_i) begin
      vld_q <= '0;
    end else begin
      if (bus.fill_valid_i) begin
        mem_q[bus.fill_addr_i] <= bus.fill_data_i;
        vld_q[bus.fill_addr_i] <= 1'b1;
      end
      if (wb_hit) begin
        mem_q[opd_addr_q] <= bus.opd_data_i;
        vld_q[opd_addr_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op0_addr_q <= '0;
      op1_addr_q <= '0;
      opd_addr_q <= '0;
      ready_q    <= 1'b1;
      succ_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      succ_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.flush_i) begin
        state_q <= IDLE;
        ready_q <= 1'b1;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (bus.req_valid_i) begin
              op0_addr_q <= bus.req_op0_addr_i;
              op1_addr_q <= bus.req_op1_addr_i;
              opd_addr_q <= bus.req_opd_addr_i;
              state_q    <= EXEC;
              ready_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end
          end
          EXEC: begin
            if (wb_hit) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              succ_q  <= 1'b1;
              done_q  <= 1'b1;
            end else if (wb_miss) begin
              err_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.req_ready_o         = ready_q;
  assign bus.op0_data_o          = mem_q[op0_addr_q];
  assign bus.op1_data_o          = mem_q[op1_addr_q];
  assign bus.op0_valid_o         = vld_q[op0_addr_q];
  assign bus.op1_valid_o         = vld_q[op1_addr_q];
  assign bus.opd_addr_o          = opd_addr_q;
  assign bus.opd_store_success_o = succ_q;
  assign bus.instr_done_o        = done_q;
  assign bus.err_o               = err_q;
endmodule

// File: tb/tb_alu_operand_server.sv
// Directed bench for alu_operand_server: the bench plays issue unit and ALU; expected writebacks go through a scoreboard.
module tb_alu_operand_server;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  int   cyc;
  int   d1_cyc;
  logic prev_succ;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  alu_operand_server_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  alu_operand_server #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Store-success monitor: pops the scoreboard and checks the pulse never repeats back to back.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.opd_store_success_o) begin
        check("succ_not_consecutive", {31'd0, prev_succ}, 32'd0);
        check("sb_entry_present", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_store_addr", {28'd0, bus.opd_addr_o}, {28'd0, e.addr});
        end
      end
      prev_succ <= bus.opd_store_success_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [3:0] a, input logic [15:0] d);
    bus.fill_valid_i = 1'b1;
    bus.fill_addr_i  = a;
    bus.fill_data_i  = d;
    tick();
    bus.fill_valid_i = 1'b0;
  endtask

  task automatic issue(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] ad);
    bus.req_valid_i    = 1'b1;
    bus.req_op0_addr_i = a0;
    bus.req_op1_addr_i = a1;
    bus.req_opd_addr_i = ad;
    check("issue_ready", {31'd0, bus.req_ready_o}, 32'd1);
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic alu_wb(input logic [3:0] a, input logic [15:0] d, input bit expect_store);
    exp_t e;
    bus.opd_valid_i = 1'b1;
    bus.opd_addr_i  = a;
    bus.opd_data_i  = d;
    if (expect_store) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    tick();
    bus.opd_valid_i = 1'b0;
  endtask

  // Reads entry a through op0 and completes the instruction by rewriting the expected value.
  task automatic read_entry(input string tag, input logic [3:0] a, input logic [15:0] d, input logic v);
    issue(a, a, a);
    check({tag, "_data"}, {16'd0, bus.op0_data_o}, {16'd0, d});
    check({tag, "_valid"}, {31'd0, bus.op0_valid_o}, {31'd0, v});
    alu_wb(a, d, 1'b1);
    check({tag, "_done"}, {31'd0, bus.instr_done_o}, 32'd1);
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    d1_cyc = 0;
    prev_succ = 1'b0;
    reset_n = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_op0_addr_i = '0;
    bus.req_op1_addr_i = '0;
    bus.req_opd_addr_i = '0;
    bus.opd_valid_i = 1'b0;
    bus.opd_addr_i = '0;
    bus.opd_data_i = '0;
    bus.fill_valid_i = 1'b0;
    bus.fill_addr_i = '0;
    bus.fill_data_i = '0;
    bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    check("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("rst_op0_valid", {31'd0, bus.op0_valid_o}, 32'd0);
    check("rst_op1_valid", {31'd0, bus.op1_valid_o}, 32'd0);
    check("rst_op0_data", {16'd0, bus.op0_data_o}, 32'd0);
    check("rst_op1_data", {16'd0, bus.op1_data_o}, 32'd0);
    check("rst_opd_addr", {28'd0, bus.opd_addr_o}, 32'd0);
    check("rst_succ", {31'd0, bus.opd_store_success_o}, 32'd0);
    check("rst_done", {31'd0, bus.instr_done_o}, 32'd0);
    check("rst_err", {31'd0, bus.err_o}, 32'd0);

    // Basic instruction with a combinational ALU
    do_fill(4'd1, 16'h0005);
    do_fill(4'd2, 16'h0003);
    issue(4'd1, 4'd2, 4'd4);
    check("t1_exec_ready", {31'd0, bus.req_ready_o}, 32'd0);
    check("t1_op0_valid", {31'd0, bus.op0_valid_o}, 32'd1);
    check("t1_op1_valid", {31'd0, bus.op1_valid_o}, 32'd1);
    check("t1_op0_data", {16'd0, bus.op0_data_o}, 32'h0005);
    check("t1_op1_data", {16'd0, bus.op1_data_o}, 32'h0003);
    check("t1_opd_addr", {28'd0, bus.opd_addr_o}, 32'd4);
    alu_wb(4'd4, 16'h0008, 1'b1);
    check("t1_succ", {31'd0, bus.opd_store_success_o}, 32'd1);
    check("t1_done", {31'd0, bus.instr_done_o}, 32'd1);
    check("t1_done_ready", {31'd0, bus.req_ready_o}, 32'd1);
    tick();
    check("t1_succ_drop", {31'd0, bus.opd_store_success_o}, 32'd0);
    check("t1_done_drop", {31'd0, bus.instr_done_o}, 32'd0);
    read_entry("t1_rd4", 4'd4, 16'h0008, 1'b1);

    // Operand missing until a late fill
    issue(4'd1, 4'd6, 4'd7);
    for (int i = 0; i < 10; i++) begin
      check("t2_op1_waiting", {31'd0, bus.op1_valid_o}, 32'd0);
      check("t2_still_exec", {31'd0, bus.req_ready_o}, 32'd0);
      tick();
    end
    bus.fill_valid_i = 1'b1;
    bus.fill_addr_i  = 4'd6;
    bus.fill_data_i  = 16'h0011;
    check("t2_fill_cycle", {31'd0, bus.op1_valid_o}, 32'd0);
    tick();
    bus.fill_valid_i = 1'b0;
    check("t2_op1_valid", {31'd0, bus.op1_valid_o}, 32'd1);
    check("t2_op1_data", {16'd0, bus.op1_data_o}, 32'h0011);
    alu_wb(4'd7, 16'h0016, 1'b1);
    check("t2_done", {31'd0, bus.instr_done_o}, 32'd1);
    tick();

    // Same-cycle fill and writeback: same address, then different addresses
    issue(4'd1, 4'd2, 4'd4);
    bus.fill_valid_i = 1'b1;
    bus.fill_addr_i  = 4'd4;
    bus.fill_data_i  = 16'hAAAA;
    alu_wb(4'd4, 16'h1234, 1'b1);
    bus.fill_valid_i = 1'b0;
    tick();
    read_entry("t3_rd4", 4'd4, 16'h1234, 1'b1);
    issue(4'd1, 4'd2, 4'd10);
    bus.fill_valid_i = 1'b1;
    bus.fill_addr_i  = 4'd11;
    bus.fill_data_i  = 16'h00B0;
    alu_wb(4'd10, 16'h00A0, 1'b1);
    bus.fill_valid_i = 1'b0;
    tick();
    read_entry("t3_rd10", 4'd10, 16'h00A0, 1'b1);
    read_entry("t3_rd11", 4'd11, 16'h00B0, 1'b1);

    // Mismatched result address
    issue(4'd1, 4'd2, 4'd4);
    alu_wb(4'd5, 16'hDEAD, 1'b0);
    check("t4_err", {31'd0, bus.err_o}, 32'd1);
    check("t4_stay_exec", {31'd0, bus.req_ready_o}, 32'd0);
    check("t4_no_succ", {31'd0, bus.opd_store_success_o}, 32'd0);
    alu_wb(4'd4, 16'h0044, 1'b1);
    check("t4_succ", {31'd0, bus.opd_store_success_o}, 32'd1);
    check("t4_err_sticky", {31'd0, bus.err_o}, 32'd1);
    tick();
    read_entry("t4_rd5", 4'd5, 16'h0000, 1'b0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("t4_err_cleared", {31'd0, bus.err_o}, 32'd0);

    // Back-to-back with the second request taken in DONE
    do_fill(4'd1, 16'h0005);
    do_fill(4'd2, 16'h0003);
    issue(4'd1, 4'd2, 4'd4);
    alu_wb(4'd4, 16'h0050, 1'b1);
    d1_cyc = cyc;
    check("t5_done1", {31'd0, bus.instr_done_o}, 32'd1);
    issue(4'd4, 4'd1, 4'd8);
    check("t5_accepted", {31'd0, bus.req_ready_o}, 32'd0);
    check("t5_fwd_data", {16'd0, bus.op0_data_o}, 32'h0050);
    check("t5_fwd_valid", {31'd0, bus.op0_valid_o}, 32'd1);
    alu_wb(4'd8, 16'h0055, 1'b1);
    check("t5_done2", {31'd0, bus.instr_done_o}, 32'd1);
    check("t5_done_spacing", cyc - d1_cyc, 32'd2);
    tick();
    issue(4'd4, 4'd1, 4'd4);
    check("t5_src_eq_dst", {16'd0, bus.op0_data_o}, 32'h0050);
    alu_wb(4'd4, 16'h0060, 1'b1);
    tick();
    read_entry("t5_rd4", 4'd4, 16'h0060, 1'b1);

    // Flush in EXEC alongside a matching writeback
    issue(4'd1, 4'd2, 4'd4);
    bus.flush_i = 1'b1;
    alu_wb(4'd4, 16'h7777, 1'b0);
    bus.flush_i = 1'b0;
    check("t6_no_succ", {31'd0, bus.opd_store_success_o}, 32'd0);
    check("t6_no_done", {31'd0, bus.instr_done_o}, 32'd0);
    check("t6_idle", {31'd0, bus.req_ready_o}, 32'd1);
    check("t6_op0_invalid", {31'd0, bus.op0_valid_o}, 32'd0);
    check("t6_op1_invalid", {31'd0, bus.op1_valid_o}, 32'd0);
    tick();
    read_entry("t6_rd4", 4'd4, 16'h0060, 1'b0);
    read_entry("t6_rd1", 4'd1, 16'h0005, 1'b0);

    tick();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
